// File: rtl/miller_rabin_pkg.sv
// Shared types and constants for the Miller-Rabin primality tester.
package miller_rabin_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_DECOMP,
        ST_ROUND,
        ST_EXP,
        ST_WITNESS,
        ST_DONE
    } mr_state_e;

    typedef enum logic {
        MM_IDLE,
        MM_RUN
    } mm_state_e;

    // Round i uses base BASE0 + i.
    localparam int BASE0 = 2;

endpackage

// File: rtl/miller_rabin_mod_mult.sv
// Serial modular multiplier: result = a*b mod m, one multiplier bit per cycle, MSB first.
// Operand a must already be reduced below m.
module mod_mult
    import miller_rabin_pkg::*;
#(
    parameter int WORD_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] a,
    input  logic [WORD_WIDTH-1:0] b,
    input  logic [WORD_WIDTH-1:0] m,
    output logic [WORD_WIDTH-1:0] result,
    output logic                  busy,
    output logic                  valid
);

    localparam int XW = WORD_WIDTH + 2;
    localparam int CW = $clog2(WORD_WIDTH + 1);

    mm_state_e             state_q;
    logic [WORD_WIDTH-1:0] r_q, r_d, a_q, b_q, m_q;
    logic [CW-1:0]         cnt_q;
    logic                  valid_q;
    logic [XW-1:0]         acc, m1, m2;

    // 2r + a < 3m, so at most one of m or 2m has to come off to land below m.
    always_comb begin
        m1  = {2'b00, m_q};
        m2  = {1'b0, m_q, 1'b0};
        acc = {1'b0, r_q, 1'b0} + (b_q[WORD_WIDTH-1] ? {2'b00, a_q} : '0);
        r_d = WORD_WIDTH'(acc);
        if (acc >= m2)
            r_d = WORD_WIDTH'(acc - m2);
        else if (acc >= m1)
            r_d = WORD_WIDTH'(acc - m1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MM_IDLE;
            r_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            m_q     <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                MM_IDLE: if (start) begin
                    a_q     <= a;
                    b_q     <= b;
                    m_q     <= m;
                    r_q     <= '0;
                    cnt_q   <= CW'(WORD_WIDTH);
                    state_q <= MM_RUN;
                end
                MM_RUN: if (cnt_q != '0) begin
                    r_q   <= r_d;
                    b_q   <= b_q << 1;
                    cnt_q <= cnt_q - CW'(1);
                end else begin
                    valid_q <= 1'b1;
                    state_q <= MM_IDLE;
                end
                default: state_q <= MM_IDLE;
            endcase
        end
    end

    assign result = r_q;
    assign busy   = (state_q == MM_RUN);
    assign valid  = valid_q;

endmodule

// File: rtl/miller_rabin.sv
// Miller-Rabin controller: trivial-case filter, n-1 = d*2^s split, and t rounds
// with bases 2,3,... using a shared serial modular multiplier.
module miller_rabin
    import miller_rabin_pkg::*;
#(
    parameter int WORD_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [WORD_WIDTH-1:0] n,
    input  logic [5:0]            t,
    output logic                  done,
    output logic                  is_prime
);

    localparam int BPW = $clog2(WORD_WIDTH);

    mr_state_e             state_q;
    logic [WORD_WIDTH-1:0] n_q, d_q, x_q, mm_a_q, mm_b_q;
    logic [5:0]            t_q, s_q, round_q, sq_cnt_q;
    logic [BPW-1:0]        bp_q;
    logic                  mul_ph_q, wait_q, mm_start_q, done_q, is_prime_q;
    logic [WORD_WIDTH-1:0] base, nm1, mm_result;
    logic                  mm_busy, mm_valid;

    assign base = WORD_WIDTH'(round_q) + WORD_WIDTH'(BASE0);
    assign nm1  = n_q - WORD_WIDTH'(1);

    mod_mult #(.WORD_WIDTH(WORD_WIDTH)) u_mm (
        .clk    (clk),
        .rst    (rst),
        .start  (mm_start_q),
        .a      (mm_a_q),
        .b      (mm_b_q),
        .m      (n_q),
        .result (mm_result),
        .busy   (mm_busy),
        .valid  (mm_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            n_q        <= '0;
            d_q        <= '0;
            x_q        <= '0;
            mm_a_q     <= '0;
            mm_b_q     <= '0;
            t_q        <= '0;
            s_q        <= '0;
            round_q    <= '0;
            sq_cnt_q   <= '0;
            bp_q       <= '0;
            mul_ph_q   <= 1'b0;
            wait_q     <= 1'b0;
            mm_start_q <= 1'b0;
            done_q     <= 1'b0;
            is_prime_q <= 1'b0;
        end else begin
            mm_start_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: if (enable) begin
                    n_q        <= n;
                    t_q        <= (t == 6'd0) ? 6'd1 : t;
                    done_q     <= 1'b0;
                    is_prime_q <= 1'b0;
                    state_q    <= ST_CHECK;
                end
                ST_CHECK: begin
                    d_q <= nm1;
                    s_q <= '0;
                    if (n_q < WORD_WIDTH'(2) || (n_q > WORD_WIDTH'(3) && !n_q[0])) begin
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else if (n_q < WORD_WIDTH'(4)) begin
                        done_q     <= 1'b1;
                        is_prime_q <= 1'b1;
                        state_q    <= ST_DONE;
                    end else begin
                        state_q <= ST_DECOMP;
                    end
                end
                ST_DECOMP: if (!d_q[0]) begin
                    d_q <= d_q >> 1;
                    s_q <= s_q + 6'd1;
                end else begin
                    round_q <= '0;
                    state_q <= ST_ROUND;
                end
                ST_ROUND: if (round_q == t_q) begin
                    done_q     <= 1'b1;
                    is_prime_q <= 1'b1;
                    state_q    <= ST_DONE;
                end else if (base >= nm1) begin
                    round_q <= round_q + 6'd1;
                end else begin
                    x_q      <= WORD_WIDTH'(1);
                    bp_q     <= BPW'(WORD_WIDTH - 1);
                    mul_ph_q <= 1'b0;
                    state_q  <= ST_EXP;
                end
                // Left-to-right square-and-multiply over every bit of d; squaring
                // the leading 1s is harmless and keeps the sequencing uniform.
                ST_EXP: if (!wait_q) begin
                    if (!mm_busy) begin
                        mm_start_q <= 1'b1;
                        wait_q     <= 1'b1;
                        mm_a_q     <= x_q;
                        mm_b_q     <= mul_ph_q ? base : x_q;
                    end
                end else if (mm_valid) begin
                    wait_q <= 1'b0;
                    x_q    <= mm_result;
                    if (!mul_ph_q && d_q[bp_q]) begin
                        mul_ph_q <= 1'b1;
                    end else begin
                        mul_ph_q <= 1'b0;
                        if (bp_q == '0) begin
                            sq_cnt_q <= '0;
                            state_q  <= ST_WITNESS;
                        end else begin
                            bp_q <= bp_q - BPW'(1);
                        end
                    end
                end
                ST_WITNESS: if (!wait_q) begin
                    if (x_q == nm1 || (x_q == WORD_WIDTH'(1) && sq_cnt_q == '0)) begin
                        round_q <= round_q + 6'd1;
                        state_q <= ST_ROUND;
                    end else if (x_q == WORD_WIDTH'(1) || sq_cnt_q == s_q - 6'd1) begin
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else if (!mm_busy) begin
                        mm_start_q <= 1'b1;
                        wait_q     <= 1'b1;
                        mm_a_q     <= x_q;
                        mm_b_q     <= x_q;
                    end
                end else if (mm_valid) begin
                    wait_q   <= 1'b0;
                    x_q      <= mm_result;
                    sq_cnt_q <= sq_cnt_q + 6'd1;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign done     = done_q;
    assign is_prime = is_prime_q;

endmodule

// File: tb/tb_miller_rabin.sv
// Directed bench for miller_rabin: each vector is checked against a hand literal,
// against a plain-arithmetic Miller-Rabin model, and per-cycle while done is high.
module tb_miller_rabin;

    localparam int LIMIT = 40000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [31:0] n = '0;
    logic [5:0]  t = '0;
    logic        done, is_prime;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;
    bit exp_prime = 1'b0;

    miller_rabin #(.WORD_WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .n        (n),
        .t        (t),
        .done     (done),
        .is_prime (is_prime)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic longint unsigned powmod(longint unsigned b, longint unsigned e,
                                               longint unsigned m);
        longint unsigned r = 1 % m;
        b = b % m;
        while (e != 0) begin
            if (e % 2 == 1) r = (r * b) % m;
            b = (b * b) % m;
            e = e / 2;
        end
        return r;
    endfunction

    function automatic bit mr_model(longint unsigned nn, int tt);
        longint unsigned d, x;
        int s, rounds;
        bit comp;
        if (nn < 2) return 1'b0;
        if (nn < 4) return 1'b1;
        if (nn % 2 == 0) return 1'b0;
        d = nn - 1;
        s = 0;
        while (d % 2 == 0) begin
            d = d / 2;
            s++;
        end
        rounds = (tt == 0) ? 1 : tt;
        for (int i = 0; i < rounds; i++) begin
            longint unsigned a = longint'(i) + 2;
            if (a >= nn - 1) continue;
            x = powmod(a, d, nn);
            if (x == 1 || x == nn - 1) continue;
            comp = 1'b1;
            for (int r = 1; r < s; r++) begin
                x = (x * x) % nn;
                if (x == nn - 1) begin
                    comp = 1'b0;
                    break;
                end
            end
            if (comp) return 1'b0;
        end
        return 1'b1;
    endfunction

    // While a verdict is on display it must match the model for the accepted vector.
    always @(negedge clk) begin
        if (chk_en && !rst && done === 1'b1)
            chk("verdict_hold", {63'd0, is_prime}, {63'd0, exp_prime});
    end

    task automatic run_test(input logic [31:0] nv, input logic [5:0] tv, input bit lit,
                            input string name, input bit trivial, input bit noise);
        int cyc;
        bit m;
        m = mr_model(longint'(nv), int'(tv));
        chk({name, "_model"}, {63'd0, m}, {63'd0, lit});
        @(negedge clk);
        n = nv;
        t = tv;
        enable = 1'b1;
        @(posedge clk);
        #1;
        enable = 1'b0;
        n = $urandom;
        t = 6'($urandom);
        chk({name, "_drop"}, {63'd0, done}, 64'd0);
        exp_prime = m;
        chk_en = 1'b1;
        cyc = 0;
        while (done !== 1'b1 && cyc < LIMIT) begin
            @(negedge clk);
            cyc++;
            if (noise && (cyc == 20 || cyc == 300)) begin
                enable = 1'b1;
                n = 32'd8;
                t = 6'd1;
            end else begin
                enable = 1'b0;
            end
        end
        enable = 1'b0;
        if (done !== 1'b1) begin
            chk({name, "_timeout"}, {63'd0, done}, 64'd1);
        end else begin
            chk({name, "_verdict"}, {63'd0, is_prime}, {63'd0, lit});
            if (trivial) chk({name, "_latency_ok"}, {63'd0, (cyc <= 3)}, 64'd1);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_done", {63'd0, done}, 64'd0);
        chk("reset_prime", {63'd0, is_prime}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_test(32'd10, 6'd5, 1'b0, "n10", 1'b1, 1'b0);
        run_test(32'd7, 6'd5, 1'b1, "n7", 1'b0, 1'b0);
        run_test(32'd11, 6'd5, 1'b1, "n11", 1'b0, 1'b0);
        run_test(32'd97, 6'd5, 1'b1, "n97_busy_en", 1'b0, 1'b1);
        run_test(32'd8, 6'd5, 1'b0, "n8", 1'b1, 1'b0);
        run_test(32'd9, 6'd1, 1'b0, "n9_round0", 1'b0, 1'b0);
        run_test(32'd2047, 6'd5, 1'b0, "n2047", 1'b0, 1'b0);
        run_test(32'd2047, 6'd1, 1'b1, "n2047_base2only", 1'b0, 1'b0);
        run_test(32'd0, 6'd5, 1'b0, "n0", 1'b1, 1'b0);
        run_test(32'd1, 6'd5, 1'b0, "n1", 1'b1, 1'b0);
        run_test(32'd2, 6'd5, 1'b1, "n2", 1'b1, 1'b0);
        run_test(32'd3, 6'd5, 1'b1, "n3", 1'b1, 1'b0);
        run_test(32'd5, 6'd0, 1'b1, "n5_t0", 1'b0, 1'b0);
        run_test(32'd561, 6'd3, 1'b0, "n561", 1'b0, 1'b0);
        run_test(32'd4294967291, 6'd5, 1'b1, "nmax", 1'b0, 1'b0);

        // Abort a long test in the middle of exponentiation.
        @(negedge clk);
        n = 32'd4294967291;
        t = 6'd5;
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        chk_en = 1'b0;
        repeat (200) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_done", {63'd0, done}, 64'd0);
        chk("abort_prime", {63'd0, is_prime}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_test(32'd15, 6'd5, 1'b0, "n15_after_rst", 1'b0, 1'b0);
        run_test(32'd13, 6'd5, 1'b1, "n13_b2b", 1'b0, 1'b0);
        run_test(32'd25, 6'd2, 1'b0, "n25_b2b", 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/miller_rabin.md
# miller_rabin

Sequential Miller–Rabin primality tester for one WORD_WIDTH-bit unsigned candidate, running t rounds with a fixed deterministic base sequence. It serves the RSA key-generation path: a candidate is loaded with a start pulse, and a prime/composite verdict is returned with a done flag. Arithmetic is multi-cycle, built on a serial modular multiplier; no hardware multiplier is used.

## Interface
- WORD_WIDTH, 32, width of the candidate n and of all modular arithmetic.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  start strobe; a one-cycle pulse is sufficient.
- n  in  WORD_WIDTH  candidate; sampled only on the accepted start cycle.
- t  in  6  round count; sampled with n; t=0 is treated as 1.
- done  out  1  result valid; held high until reset or the next start.
- is_prime  out  1  verdict, 1 = probably prime; valid while done=1.

## Operation
- States: IDLE, CHECK, DECOMP, ROUND, EXP, WITNESS, DONE.
- IDLE: enable=1 latches n and t, clears done, then goes to CHECK.
- CHECK (trivial cases):
  - n<2: composite.
  - n=2 or n=3: prime.
  - even n>3: composite.
  - Each of these goes to DONE.
  - Otherwise go to DECOMP.
- DECOMP:
  - Start with d=n-1, s=0.
  - While d is even: shift d right once and increment s, one shift per cycle.
- ROUND, round i (i = 0..t-1):
  - Base a = i+2.
  - If a ≥ n-1, the round passes trivially.
  - Otherwise go to EXP.
- EXP: x = a^d mod n by left-to-right square-and-multiply, using mod_mult.
- WITNESS:
  - If x=1 or x=n-1, the round passes.
  - Else square x up to s-1 times; reaching n-1 means the round passes.
  - Reaching 1, or exhausting the squarings, means composite: go to DONE at once.
- All t rounds pass: prime.
- DONE:
  - done=1, is_prime holds the verdict.
  - A new enable restarts from a freshly latched n and t; done drops the cycle after acceptance.
- Arithmetic rules:
  - Every intermediate result is reduced to below n.
  - The multiplier works internally at WORD_WIDTH+2 bits so it cannot overflow for any n < 2^WORD_WIDTH.
- enable while busy (any state other than IDLE or DONE) is ignored.
- n and t may change after acceptance without effect.

## Timing
- Reset: done=0, is_prime=0, state IDLE, internal registers cleared. Reset is honoured in every state, including mid-computation, and aborts the current test.
- Start: the enable edge moves IDLE to CHECK on the next clock.
- Trivial cases: done=1 no more than 3 cycles after the enable edge.
- mod_mult:
  - Fixed latency of WORD_WIDTH+2 cycles per product.
  - start/busy handshake with the controller.
  - One operation in flight at a time.
- Worst case per round: about (2·WORD_WIDTH + s)·(WORD_WIDTH+3) cycles.
- Total latency ≤ t × that bound + WORD_WIDTH + 4.
- done and is_prime are registered outputs and never glitch.

## Structure
- Package miller_rabin_pkg holds:
  - the state enum type;
  - the mod_mult state enum;
  - the base offset constant BASE0 = 2.
- Sub-module mod_mult (parameter WORD_WIDTH): computes a·b mod n by MSB-first interleaved shift/add/conditional-subtract.
  - Ports: clk, rst, start, a, b, m, result, busy/valid.
  - It is reused for both squaring and multiplying.
- Top-level controller: the FSM, the d/s/counter registers, the exponent bit pointer and the round counter.

## Test plan
- Reset, then n=10, t=5, enable pulse: done=1 within 3 cycles, is_prime=0.
- Primes:
  - n=7, t=5: is_prime=1.
  - n=11, t=5: is_prime=1.
  - n=97, t=5: is_prime=1.
  - n=4294967291 (largest 32-bit prime), t=5: is_prime=1.
- Composites:
  - n=8: is_prime=0.
  - n=9: is_prime=0, witness found in round 0.
  - n=2047 = 23·89, strong pseudoprime to base 2, t=5: is_prime=0, caught by base 3.
- Edges:
  - n=0: is_prime=0.
  - n=1: is_prime=0.
  - n=2: is_prime=1.
  - n=3: is_prime=1.
  - n=5, t=0: is_prime=1 (treated as 1 round; base 2 < n-1, so the round is actually run).
- Control:
  - rst asserted mid-EXP for n=4294967291: done=0 and is_prime=0 on the next cycle.
  - Re-run with n=15: is_prime=0.
  - enable pulses while busy are ignored; the verdict is unchanged.
- Back-to-back: after done, enable with n=13 without reset: done=0 the next cycle, then done=1, is_prime=1.
